// File: rtl/hilo_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer_if
// Purpose  : Bundles the EX-stage request, ID-stage hazard inputs, WB-stage
//            MTHI/MTLO write port and the HI/LO / pipeline-control outputs
//            of the HI/LO multiply/divide sequencer.
// Ports    : master - pipeline side (drives requests, reads HI/LO/stall)
//            slave  - sequencer side
//            start, op[1:0], rs_val, rt_val : EX mul/div request
//            id_hilo_read, id_muldiv        : ID-stage hazard sources
//            wb_hi_le, wb_lo_le, wb_data    : WB MTHI/MTLO write
//            hi, lo, busy, done             : HI/LO state and status
//            pc_le, ifid_le, ctrl_nop       : hazard stall controls
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            id_hilo_read;
  logic            id_muldiv;
  logic            wb_hi_le;
  logic            wb_lo_le;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            pc_le;
  logic            ifid_le;
  logic            ctrl_nop;

  modport master (
    output start, op, rs_val, rt_val,
    output id_hilo_read, id_muldiv,
    output wb_hi_le, wb_lo_le, wb_data,
    input  hi, lo, busy, done, pc_le, ifid_le, ctrl_nop
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  id_hilo_read, id_muldiv,
    input  wb_hi_le, wb_lo_le, wb_data,
    output hi, lo, busy, done, pc_le, ifid_le, ctrl_nop
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
//            Shift-add multiply / restoring divide, one bit per clock,
//            32 RUN iterations followed by a FIX (sign-correct + write) cycle.
//            Generates the PC / IF/ID stall and ID/EX bubble while an ID
//            instruction depends on HI/LO or the unit.
// Ports    : clk   - pipeline clock
//            reset - asynchronous, active-low reset
//            bus   - hilo_muldiv_sequencer_if.slave (request, WB write,
//                    HI/LO, busy/done, pc_le/ifid_le/ctrl_nop)
// Options  : MULDIV_EARLY_OUT_EN - when defined, MULT/MULTU leave RUN as
//            soon as the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic                    clk,
  input logic                    reset,
  hilo_muldiv_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Multiply: r_acc = partial product, r_opa = multiplicand (shifts left),
  //           r_opb = multiplier (shifts right).
  // Divide:   r_acc[XLEN-1:0] = partial remainder, r_opa = divisor,
  //           r_opb = dividend bits shifting out / quotient bits shifting in.
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_opa;
  logic [XLEN-1:0]   r_opb;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div_zero;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;

  // --------------------------------------------------------------------------
  // Operand conditioning: signed ops run on magnitudes, signs kept aside.
  // --------------------------------------------------------------------------
  logic            w_signed_op;
  logic            w_rs_neg;
  logic            w_rt_neg;
  logic [XLEN-1:0] w_rs_mag;
  logic [XLEN-1:0] w_rt_mag;

  assign w_signed_op = ~bus.op[0];
  assign w_rs_neg    = w_signed_op & bus.rs_val[XLEN-1];
  assign w_rt_neg    = w_signed_op & bus.rt_val[XLEN-1];
  assign w_rs_mag    = w_rs_neg ? (~bus.rs_val + XLEN'(1)) : bus.rs_val;
  assign w_rt_mag    = w_rt_neg ? (~bus.rt_val + XLEN'(1)) : bus.rt_val;

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_acc_add;
  logic [XLEN:0]     w_rem_sh;
  logic              w_fits;
  logic [XLEN-1:0]   w_rem_sub;
  logic              w_last;

  assign w_acc_add = r_acc + r_opa;

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  // The remainder is always below the divisor afterwards, so the 32-bit
  // modular difference is exact whenever w_fits is set.
  assign w_rem_sh  = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
  assign w_fits    = (w_rem_sh >= {1'b0, r_opa[XLEN-1:0]});
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_opa[XLEN-1:0];

`ifdef MULDIV_EARLY_OUT_EN
  // After this edge's shift the multiplier is r_opb >> 1; once that is zero
  // no further partial products can be added.
  assign w_last = (r_cnt == c_last_iter) ||
                  (!r_is_div && (r_opb[XLEN-1:1] == '0));
`else
  assign w_last = (r_cnt == c_last_iter);
`endif

  // --------------------------------------------------------------------------
  // Sign correction and result selection (used in FIX)
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  assign w_prod   = r_neg_q ? (~r_acc + (2*XLEN)'(1)) : r_acc;
  assign w_quot   = r_neg_q ? (~r_opb + XLEN'(1)) : r_opb;
  assign w_rem    = r_neg_r ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  // Divide by zero: the restoring loop already leaves the dividend as the
  // remainder, but the quotient would be sign-flipped for negative
  // dividends, so LO is forced to all ones.
  assign w_res_hi = r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
  assign w_res_lo = r_is_div ? (r_div_zero ? '1 : w_quot) : w_prod[XLEN-1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and hazard outputs
  // --------------------------------------------------------------------------
  logic w_busy;
  logic w_stall;

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_busy       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // FIX still counts as busy: the dependent ID instruction is held until
    // the result is in HI/LO.
    w_stall = w_busy & (bus.id_hilo_read | bus.id_muldiv);
  end

  // --------------------------------------------------------------------------
  // Datapath and HI/LO registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc      <= '0;
            r_opa      <= {{XLEN{1'b0}}, (bus.op[1] ? w_rt_mag : w_rs_mag)};
            r_opb      <= bus.op[1] ? w_rs_mag : w_rt_mag;
            r_cnt      <= '0;
            r_is_div   <= bus.op[1];
            r_neg_q    <= w_rs_neg ^ w_rt_neg;
            r_neg_r    <= w_rs_neg;
            r_div_zero <= (bus.rt_val == '0);
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + c_cnt_one;
          if (r_is_div) begin
            r_acc <= {{XLEN{1'b0}}, (w_fits ? w_rem_sub : w_rem_sh[XLEN-1:0])};
            r_opb <= {r_opb[XLEN-2:0], w_fits};
          end else begin
            if (r_opb[0]) begin
              r_acc <= w_acc_add;
            end
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end
        end
        default: begin
        end
      endcase

      // The FIX write takes priority over a same-edge MTHI/MTLO.
      if (r_state == S_FIX) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end else begin
        if (bus.wb_hi_le) begin
          r_hi <= bus.wb_data;
        end
        if (bus.wb_lo_le) begin
          r_lo <= bus.wb_data;
        end
      end
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.pc_le    = ~w_stall;
  assign bus.ifid_le  = ~w_stall;
  assign bus.ctrl_nop = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_sequencer
// Purpose  : Self-checking bench for hilo_muldiv_sequencer. Directed corner
//            operations plus random operations, compared against an
//            arithmetic reference model (64-bit products, native division).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;

  hilo_muldiv_sequencer_if #(.XLEN(32)) bus ();

  hilo_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference result {HI, LO}
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      2'b00: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = 64'(sa * sb);
      end
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          sa = $signed(a);
          sb = $signed(b);
          q  = sa / sb;
          r  = sa % sb;
          p  = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
          q  = sa / sb;
          r  = sa % sb;
          p  = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Clock edges from the start edge until done is visible
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      logic [31:0] mag;
      int n;
      mag = (op == 2'b00 && b[31]) ? (32'd0 - b) : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
      if (n < 1) n = 1;
      lat = n + 1;
    end
`else
    if (op[1]) lat = 33;
`endif
    return lat;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current cycle; returns in the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit stall_rd, input bit stall_md, input bit wb_race,
                        input string tag);
    logic [63:0] exp;
    int lat, c;
    bit got, exp_stall;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, b);
    bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    step();  // E0
    bus.start  = 1'b0;
    bus.op     = 2'($urandom);
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    chk($sformatf("%s.busy_e0", tag), 32'(bus.busy), 32'd1);
    chk($sformatf("%s.done_e0", tag), 32'(bus.done), 32'd0);
    c = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      bus.id_hilo_read = stall_rd && (c >= 5);
      bus.id_muldiv    = stall_md && (c >= 5);
      bus.start        = (c == 3);
      bus.wb_data      = 32'h1234;
      bus.wb_hi_le     = wb_race && (c == lat - 1);
      bus.wb_lo_le     = wb_race && (c == 1);
      exp_stall        = (stall_rd || stall_md) && (c >= 5);
      #1;
      chk($sformatf("%s.stall_c%0d", tag, c), {29'd0, bus.pc_le, bus.ifid_le, bus.ctrl_nop},
          {29'd0, !exp_stall, !exp_stall, exp_stall});
      step();
      bus.start = 1'b0; bus.wb_hi_le = 1'b0; bus.wb_lo_le = 1'b0;
      c++;
      got = (bus.done === 1'b1);
    end
    chk($sformatf("%s.done_seen", tag), 32'(got), 32'd1);
    chk($sformatf("%s.latency", tag), 32'(c), 32'(lat));
    chk($sformatf("%s.hi", tag), bus.hi, exp[63:32]);
    chk($sformatf("%s.lo", tag), bus.lo, exp[31:0]);
    chk($sformatf("%s.busy_done", tag), 32'(bus.busy), 32'd0);
    chk($sformatf("%s.stall_done", tag), {29'd0, bus.pc_le, bus.ifid_le, bus.ctrl_nop}, 32'd6);
    bus.id_hilo_read = 1'b0;
    bus.id_muldiv    = 1'b0;
  endtask

  initial begin
    bit seen_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.id_hilo_read = 1'b0; bus.id_muldiv = 1'b0;
    bus.wb_hi_le = 1'b0; bus.wb_lo_le = 1'b0; bus.wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hi", bus.hi, 32'd0);
    chk("rst.lo", bus.lo, 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.ctl", {29'd0, bus.pc_le, bus.ifid_le, bus.ctrl_nop}, 32'd6);
    reset = 1'b1;
    step();

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "multu_max");
    step();
    chk("multu_max.done_pulse", 32'(bus.done), 32'd0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 0, 0, "mult_neg3x7_stall");
    // start in the done cycle is accepted
    run_op(2'b11, 32'd100, 32'd7, 0, 0, 0, "divu_100_7");
    step();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1, 0, "div_neg7_2");
    step();
    run_op(2'b10, 32'd5, 32'd0, 0, 0, 0, "div_5_0");
    step();
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0, 0, "div_neg5_0");
    step();
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, "divu_x_0");
    step();
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_min_neg1");
    step();
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, "mult_min_min");
    step();
    run_op(2'b00, 32'h1234_5678, 32'd0, 0, 0, 0, "mult_zero");
    step();
    run_op(2'b01, 32'd2, 32'd3, 0, 0, 1, "multu_2x3_wbrace");
    step();

    // MTHI / MTLO while idle
    bus.wb_data = 32'h1234; bus.wb_hi_le = 1'b1;
    step();
    bus.wb_hi_le = 1'b0;
    chk("wb_idle.hi", bus.hi, 32'h1234);
    chk("wb_idle.lo", bus.lo, 32'd6);
    bus.wb_data = 32'hCAFE_0001; bus.wb_lo_le = 1'b1;
    step();
    bus.wb_lo_le = 1'b0;
    chk("wb_idle.lo2", bus.lo, 32'hCAFE_0001);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             $sformatf("rand%0d_op%0d", i, rop));
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    // Reset in the middle of a divide
    bus.op = 2'b10; bus.rs_val = $urandom | 32'h1; bus.rt_val = $urandom | 32'h1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    bus.id_hilo_read = 1'b1;
    #1;
    chk("midrst.stall_before", 32'(bus.ctrl_nop), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst.hi", bus.hi, 32'd0);
    chk("midrst.lo", bus.lo, 32'd0);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.ctl", {29'd0, bus.pc_le, bus.ifid_le, bus.ctrl_nop}, 32'd6);
    bus.id_hilo_read = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
    end
    chk("midrst.no_activity_after", 32'(seen_done), 32'd0);
    chk("midrst.hi_held", bus.hi, 32'd0);

    run_op(2'b01, 32'd12345, 32'd678, 0, 0, 0, "multu_after_reset");
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Iterative multiply/divide controller that owns the HI/LO register pair for the pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-iteration shift-add or restoring-divide sequence.
- Stalls PC, nPC and IF/ID and forces a control bubble while an ID-stage instruction needs HI/LO or the unit.
- Also absorbs WB-stage MTHI/MTLO writes (hi_enable / lo_enable).

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a mul/div instruction; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_val  input  32  multiplicand / dividend.
- rt_val  input  32  multiplier / divisor.
- id_hilo_read  input  1  ID holds MFHI or MFLO.
- id_muldiv  input  1  ID holds a mul/div instruction.
- wb_hi_le  input  1  WB write enable for HI (MTHI).
- wb_lo_le  input  1  WB write enable for LO (MTLO).
- wb_data  input  32  WB write data.
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  unit not in IDLE.
- done  output  1  one-cycle pulse when a new HI/LO result is written.
- pc_le  output  1  load enable for PC and nPC.
- ifid_le  output  1  load enable for the IF/ID register.
- ctrl_nop  output  1  selects zero control word into ID/EX.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operands=0.
  - pc_le and ifid_le read 1; ctrl_nop reads 0.
  - Reset asserted mid-operation aborts immediately, with no partial HI/LO write.
- States:
  - IDLE: start=1 at edge E0 loads operands and goes to RUN. Signed ops load magnitudes and record result signs: product sign = sign(rs) XOR sign(rt); quotient same; remainder sign = sign(rs).
  - RUN: one iteration per edge, counter 0..31. Multiply is shift-add on a 64-bit accumulator. Divide is restoring, one quotient bit per edge. After the 32nd iteration (edge E32) go to FIX.
  - FIX: at edge E33, apply sign correction, write HI/LO, done=1 for exactly one cycle, state goes to IDLE.
- Latency:
  - busy=1 from after E0 until after E33.
  - Result visible on hi/lo and done=1 in the cycle following E33.
  - Fixed 33 edges unless the optional feature is enabled.
- Results:
  - Multiply: HI = upper 32 bits, LO = lower 32 bits of the 64-bit product.
  - Divide: LO = quotient, HI = remainder; remainder sign follows dividend.
- Divide by zero (rt_val=0): still runs full latency. Result HI=rs_val, LO=0xFFFFFFFF. No exception, no error flag.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Stall: stall = busy AND (id_hilo_read OR id_muldiv).
  - pc_le = ifid_le = NOT stall; ctrl_nop = stall.
  - Combinational from state and inputs.
  - In the FIX cycle busy=1, so stall still holds; the ID instruction proceeds on the following cycle.
- start while busy: ignored. The hazard stall makes this unreachable in correct operation; the bench checks it is ignored anyway.
- start in the cycle right after done (IDLE again): accepted normally.
- WB writes:
  - wb_hi_le / wb_lo_le write wb_data on the edge in any state.
  - If a WB write and the FIX write land on the same edge, the FIX result wins.
  - A WB write during RUN is overwritten at FIX.
- op sampled only at E0; later changes on op, rs_val or rt_val have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU only, RUN exits to FIX on the edge after the remaining unshifted multiplier bits become all zero. Minimum is 1 RUN edge; a zero multiplier gives done in the cycle after E2. Results are identical; divide always takes 32 iterations.
- Undefined: fixed 32 RUN iterations for every op.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after E33 HI=0xFFFFFFFE, LO=0x00000001, done=1 for one cycle, busy=0 after E33.
- MULT rs=0xFFFFFFFD(-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIVU 100/7 -> LO=14, HI=2.
- DIV rs=0xFFFFFFF9(-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV rs=5 rt=0 -> HI=5, LO=0xFFFFFFFF.
- Start MULT, then id_hilo_read=1 from cycle 5 -> pc_le=ifid_le=0, ctrl_nop=1 through the FIX cycle; all return to 1/1/0 in the done cycle; with id_hilo_read=0, no stall at any time.
- wb_hi_le=1, wb_data=0x1234 at edge E33 of a MULTU 2*3 -> HI=0, LO=6 (FIX wins); the same write in IDLE -> HI=0x1234.
- reset=0 at cycle 10 of a DIV -> hi=lo=0, busy=0, done=0 immediately; no done pulse after reset releases.
